// File: rtl/csa_pkg.sv
// Shared defaults for the carry-select adder and its issue/collect stage:
// adder geometry, default tag width and the packed result-entry width.
package csa_pkg;

  localparam int CSA_WIDTH = 18;
  localparam int CSA_M     = 6;
  localparam int CSA_TAGW  = 4;
  localparam int CSA_RES_W = CSA_WIDTH + 1 + CSA_TAGW;

  // A result entry packs {sum, cout, tag}.
  function automatic int res_entry_w(input int width, input int tagw);
    return width + 1 + tagw;
  endfunction

endpackage

// File: rtl/csa_sync_fifo.sv
// Synchronous FIFO with a show-ahead head (dout is the oldest entry).
// Push while full and pop while empty are ignored.
module csa_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         push_ok;
  logic         pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wr_q - rd_q;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    wr_d    = wr_q + {{AW{1'b0}}, push_ok};
    rd_d    = rd_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/csa_issue_ctrl.sv
// Issue/collect stage in front of the pipelined carry-select adder.
// Optional build macro CSA_ISSUE_STATS_EN adds stat_issued / stat_stall counters.
module csa_issue_ctrl
  import csa_pkg::*;
#(
  parameter int WIDTH   = CSA_WIDTH,
  parameter int ADD_LAT = 1,
  parameter int QDEPTH  = 4,
  parameter int RDEPTH  = 4,
  parameter int TAGW    = CSA_TAGW
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CSA_ISSUE_STATS_EN
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_stall,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAGW-1:0]  out_tag
);

  localparam int OPW  = 2 * WIDTH + TAGW;
  localparam int RESW = res_entry_w(WIDTH, TAGW);
  localparam int QCW  = $clog2(QDEPTH) + 1;
  localparam int RCW  = $clog2(RDEPTH) + 1;
  localparam int OCCW = $clog2(RDEPTH + ADD_LAT + 1) + 1;

  logic [OPW-1:0]   op_head;
  logic             op_full, op_empty;
  logic [QCW-1:0]   op_count;
  logic [RESW-1:0]  res_head;
  logic             res_full, res_empty;
  logic [RCW-1:0]   res_count;
  logic             push, issue, capture, credit_zero;
  logic [OCCW-1:0]  occupancy;
  logic             unused_status;

  logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [ADD_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [TAGW-1:0]  pipe_tag_q [ADD_LAT];
  logic [TAGW-1:0]  pipe_tag_d [ADD_LAT];

  assign in_ready = !op_full && !rst;
  assign push     = in_valid && in_ready;

  csa_sync_fifo #(.W(OPW), .DEPTH(QDEPTH)) u_op_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({in_a, in_b, in_tag}),
    .pop   (issue),
    .dout  (op_head),
    .full  (op_full),
    .empty (op_empty),
    .count (op_count)
  );

  // Credits reserve a result slot for every in-flight op, so capture never overflows.
  always_comb begin
    occupancy = OCCW'(res_count);
    for (int i = 0; i < ADD_LAT; i++) begin
      occupancy = occupancy + OCCW'(pipe_v_q[i]);
    end
    credit_zero = (occupancy >= OCCW'(RDEPTH));
    issue       = !op_empty && !credit_zero && !res_full;
  end

  always_comb begin
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (issue) begin
      add_a_d = op_head[OPW-1 -: WIDTH];
      add_b_d = op_head[TAGW +: WIDTH];
    end
    pipe_v_d      = '0;
    pipe_v_d[0]   = issue;
    pipe_tag_d[0] = op_head[TAGW-1:0];
    for (int i = 1; i < ADD_LAT; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_q  <= '0;
      add_b_q  <= '0;
      pipe_v_q <= '0;
      for (int i = 0; i < ADD_LAT; i++) pipe_tag_q[i] <= '0;
    end else begin
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      pipe_v_q <= pipe_v_d;
      for (int i = 0; i < ADD_LAT; i++) pipe_tag_q[i] <= pipe_tag_d[i];
    end
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign capture = pipe_v_q[ADD_LAT-1];

  csa_sync_fifo #(.W(RESW), .DEPTH(RDEPTH)) u_res_q (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   ({add_sum, add_cout, pipe_tag_q[ADD_LAT-1]}),
    .pop   (out_valid && out_ready),
    .dout  (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  assign out_valid = !res_empty;
  assign {out_sum, out_cout, out_tag} = res_head;

  // Operand-queue occupancy is only needed as full/empty.
  assign unused_status = ^op_count;

`ifdef CSA_ISSUE_STATS_EN
  logic [31:0] issued_q, issued_d, stall_q, stall_d;

  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (issue && (issued_q != '1)) issued_d = issued_q + 32'd1;
    if (!op_empty && credit_zero && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_csa_issue_ctrl.sv
// Bench for csa_issue_ctrl with a behavioural single-cycle adder in the loop;
// a scoreboard queue holds expected {sum,cout,tag} entries in push order.
module tb_csa_issue_ctrl;

  localparam int WIDTH   = 18;
  localparam int TAGW    = 4;
  localparam int ADD_LAT = 1;
  localparam int QDEPTH  = 4;
  localparam int RDEPTH  = 4;
  localparam int RESW    = WIDTH + 1 + TAGW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [TAGW-1:0]  in_tag = '0;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [TAGW-1:0]  out_tag;
`ifdef CSA_ISSUE_STATS_EN
  logic [31:0]      stat_issued, stat_stall;
`endif

  logic [RESW-1:0]  exp_q[$];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               n_accepted = 0;
  int               rdy_mode = 0;

  csa_issue_ctrl #(
    .WIDTH(WIDTH), .ADD_LAT(ADD_LAT), .QDEPTH(QDEPTH), .RDEPTH(RDEPTH), .TAGW(TAGW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CSA_ISSUE_STATS_EN
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_tag   (out_tag)
  );

  // Adder stand-in: result settles within the cycle after A/B change.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- reference model ----------------
  function automatic logic [RESW-1:0] ref_result(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [TAGW-1:0]  t);
    longint s, m;
    logic [WIDTH-1:0] lo;
    logic c;
    m  = longint'(1) << WIDTH;
    s  = longint'(a) + longint'(b);
    lo = WIDTH'(s % m);
    c  = (s >= m);
    return {lo, c, t};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic push_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAGW-1:0] t);
    int guard = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    while (!in_ready && guard < 200) begin
      step(1);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
    end else begin
      exp_q.push_back(ref_result(a, b, t));
      n_accepted++;
      step(1);
    end
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      step(1);
      guard++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    n_accepted = 0;
    step(2);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got sum=%0h cout=%0b tag=%0h, required no output",
                 out_sum, out_cout, out_tag);
      end else begin
        logic [RESW-1:0] e;
        e = exp_q.pop_front();
        if ({out_sum, out_cout, out_tag} !== e) begin
          n_fail++;
          $display("FAIL out_result: got sum=%0h cout=%0b tag=%0h, required sum=%0h cout=%0b tag=%0h",
                   out_sum, out_cout, out_tag, e[RESW-1 -: WIDTH], e[TAGW], e[TAGW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] blk_a [8];

  initial begin
    step(1);
    do_reset();
`ifdef CSA_ISSUE_STATS_EN
    check("stat_issued_reset", stat_issued, 32'd0);
    check("stat_stall_reset", stat_stall, 32'd0);
`endif

    // Single op: result visible after push, issue and capture edges.
    rdy_mode = 1;
    step(2);
    push_op(18'd16, 18'd16, 4'd1);
    in_valid = 1'b0;
    check("lat_after_push", 32'(out_valid), 32'd0);
    step(1);
    check("lat_after_issue", 32'(out_valid), 32'd0);
    step(1);
    check("lat_after_capture", 32'(out_valid), 32'd1);
    wait_drain("drain_single");

    // Back-to-back ops emerge on consecutive cycles.
    step(2);
    push_op(18'd55, 18'd65, 4'd2);
    push_op(18'd5, 18'd2, 4'd3);
    push_op(18'd100, 18'd100, 4'd4);
    in_valid = 1'b0;
    check("b2b_valid0", 32'(out_valid), 32'd1);
    step(1);
    check("b2b_valid1", 32'(out_valid), 32'd1);
    step(1);
    check("b2b_valid2", 32'(out_valid), 32'd1);
    step(1);
    check("b2b_valid3", 32'(out_valid), 32'd0);
    wait_drain("drain_b2b");

    // Wrap-around cases.
    push_op(18'h3FFFF, 18'h00001, 4'd5);
    push_op(18'h3FFFF, 18'h3FFFF, 4'd6);
    in_valid = 1'b0;
    wait_drain("drain_wrap");

    // Back-pressure: 4 issued, 4 queued, then input stalls.
    rdy_mode = 0;
    step(2);
    for (int i = 0; i < 8; i++) begin
      blk_a[i] = WIDTH'($urandom);
      push_op(blk_a[i], WIDTH'($urandom), TAGW'(i));
    end
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    step(4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_last_issued_a", 32'(add_a), 32'(blk_a[3]));
    check("bp_scoreboard_depth", 32'(exp_q.size()), 32'd8);
    in_valid = 1'b0;
    rdy_mode = 1;
    wait_drain("drain_bp");
`ifdef CSA_ISSUE_STATS_EN
    check("stat_issued_count", stat_issued, 32'(n_accepted));
`endif

    // Reset mid-operation discards everything.
    rdy_mode = 0;
    step(2);
    for (int i = 0; i < 5; i++) push_op(WIDTH'($urandom), WIDTH'($urandom), TAGW'(i));
    do_reset();
    rdy_mode = 1;
    step(6);
    check("after_rst_out_valid", 32'(out_valid), 32'd0);
    push_op(18'd1234, 18'd4321, 4'd9);
    in_valid = 1'b0;
    wait_drain("drain_after_rst");

    // Randomized traffic with random back-pressure.
    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      logic [WIDTH-1:0] a, b;
      case ($urandom_range(0, 3))
        0: begin a = 18'h3FFFF; b = WIDTH'($urandom); end
        1: begin a = '0; b = WIDTH'($urandom); end
        2: begin a = WIDTH'($urandom_range(0, 255)); b = WIDTH'($urandom_range(0, 255)); end
        default: begin a = WIDTH'($urandom); b = WIDTH'($urandom); end
      endcase
      push_op(a, b, TAGW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step($urandom_range(1, 3));
      end
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    wait_drain("drain_random");
    step(3);
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
